// File: rtl/max7219_display_pkg.sv
// Shared definitions for the MAX7219 display driver: register map, Code-B
// glyphs, sequencer states and the preset-message table.
package max7219_display_pkg;

  localparam logic [7:0] ADDR_DECODE  = 8'h09;
  localparam logic [7:0] ADDR_INTENS  = 8'h0A;
  localparam logic [7:0] ADDR_SCANLIM = 8'h0B;
  localparam logic [7:0] ADDR_SHUTDN  = 8'h0C;
  localparam logic [7:0] ADDR_TEST    = 8'h0F;

  localparam logic [3:0] CB_DASH  = 4'hA;
  localparam logic [3:0] CB_E     = 4'hB;
  localparam logic [3:0] CB_H     = 4'hC;
  localparam logic [3:0] CB_L     = 4'hD;
  localparam logic [3:0] CB_P     = 4'hE;
  localparam logic [3:0] CB_BLANK = 4'hF;

  localparam int unsigned INIT_FRAMES = 4;

  typedef enum logic [1:0] {ST_INIT, ST_REFRESH, ST_IDLE} state_t;

  // Preset messages are right-aligned; digit 0 is the rightmost position.
  function automatic logic [3:0] preset_nib(input logic [3:0] code, input int i, input int msd);
    logic [3:0] nib;
    nib = CB_BLANK;
    case (code)
      4'd1: nib = CB_DASH;
      4'd2: begin
        case (i)
          0:       nib = CB_P;
          1:       nib = CB_L;
          2:       nib = CB_E;
          3:       nib = CB_H;
          default: nib = CB_BLANK;
        endcase
      end
      4'd3:    nib = (i == msd) ? CB_E : CB_DASH;
      default: nib = CB_BLANK;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/max7219_display_if.sv
// Host-side bundle of the display driver: snapshot inputs, busy, and the
// 3-wire MAX7219 serial bus.
interface max7219_display_if #(parameter int DIGIT_NUM = 8);
  logic                   latch;
  logic                   mode;
  logic [2:0]             dp;
  logic [3:0]             codes;
  logic [DIGIT_NUM*4-1:0] num;
  logic [3:0]             brightness;
  logic                   busy;
  logic                   sck;
  logic                   din;
  logic                   load;

  modport master (output latch, mode, dp, codes, num, brightness,
                  input  busy, sck, din, load);
  modport slave  (input  latch, mode, dp, codes, num, brightness,
                  output busy, sck, din, load);
endinterface

// File: rtl/max7219_display_shift.sv
// 16-bit MSB-first serializer: each bit is CLK_DIV clocks sck low then CLK_DIV
// high, followed by a 2*CLK_DIV gap with load high. done pulses on the last gap clock.
module max7219_display_shift #(
  parameter int CLK_DIV = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] word,
  output logic        sck,
  output logic        din,
  output logic        load,
  output logic        done
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0] HALF_LAST = 6'd33;

  logic             active;
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       half_cnt;
  logic [5:0]       half_idx;
  logic [15:0]      shreg;

  // half_idx numbers the half-period about to begin (1..33); 32 and 33 form the gap.
  assign half_idx = 6'd34 - half_cnt;
  assign done     = active && (div_cnt == '0) && (half_cnt == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      active   <= 1'b0;
      div_cnt  <= '0;
      half_cnt <= '0;
      shreg    <= '0;
      sck      <= 1'b0;
      din      <= 1'b0;
      load     <= 1'b1;
    end else if (start) begin
      active   <= 1'b1;
      div_cnt  <= DIV_LOAD;
      half_cnt <= HALF_LAST;
      shreg    <= word;
      sck      <= 1'b0;
      din      <= word[15];
      load     <= 1'b0;
    end else if (active) begin
      if (div_cnt != '0) begin
        div_cnt <= div_cnt - DIV_W'(1);
      end else if (half_cnt == '0) begin
        active <= 1'b0;
      end else begin
        div_cnt  <= DIV_LOAD;
        half_cnt <= half_cnt - 6'd1;
        if (half_idx >= 6'd32) begin
          sck  <= 1'b0;
          din  <= 1'b0;
          load <= 1'b1;
        end else if (half_idx[0]) begin
          sck <= 1'b1;
        end else begin
          sck   <= 1'b0;
          shreg <= {shreg[14:0], 1'b0};
          din   <= shreg[14];
        end
      end
    end
  end
endmodule

// File: rtl/max7219_display.sv
// MAX7219 sequencer: chip init after reset, then refresh sequences of intensity
// plus digit frames built from a snapshot of the host inputs.
//   state      | meaning
//   ST_INIT    | sending 0C01, 0B(scan limit), 09FF, 0F00
//   ST_REFRESH | sending intensity then one frame per digit from the snapshot
//   ST_IDLE    | waiting for latch or a pending request; only non-busy state
module max7219_display #(
  parameter int DIGIT_NUM = 8,
  parameter int CLK_DIV   = 4
) (
  input  logic             clock,
  input  logic             reset,
  max7219_display_if.slave bus
);
  import max7219_display_pkg::*;

  localparam logic [3:0] IDX_REFRESH = 4'(INIT_FRAMES);
  localparam logic [3:0] IDX_LAST    = 4'(INIT_FRAMES + DIGIT_NUM);

  state_t                 state, state_nxt;
  logic [3:0]             idx, idx_nxt;
  logic                   first, pending, start, snap_en, done;
  logic [15:0]            word;
  logic [2:0]             dsel;
  logic                   s_mode, cur_mode;
  logic [2:0]             s_dp, cur_dp;
  logic [3:0]             s_codes, cur_codes, s_bright, cur_bright;
  logic [DIGIT_NUM*4-1:0] s_num, cur_num;
  logic                   sh_sck, sh_din, sh_load;

  function automatic logic [7:0] digit_data(input logic [2:0] sel, input logic mode,
                                            input logic [2:0] dp, input logic [3:0] codes,
                                            input logic [DIGIT_NUM*4-1:0] num);
    logic [3:0] nib;
    logic       upper_zero;
    logic       dp_bit;
    int         d;
    d          = int'(sel);
    nib        = CB_BLANK;
    upper_zero = 1'b1;
    dp_bit     = 1'b0;
    if (mode) begin
      nib = preset_nib(codes, d, DIGIT_NUM - 1);
    end else begin
      for (int j = 0; j < DIGIT_NUM; j++) begin
        if (j == d) nib = num[4*j +: 4];
        if (j >= d && num[4*j +: 4] != 4'h0) upper_zero = 1'b0;
      end
      // Leading zeros blank, but never the units digit nor anything at/below the DP.
      if (d > 0 && d > int'(dp) && upper_zero) nib = CB_BLANK;
      dp_bit = (dp != 3'd0) && (d == int'(dp));
    end
    return {dp_bit, 3'b000, nib};
  endfunction

  // The frame launched on the snapshot clock must already see the new inputs.
  assign cur_mode   = snap_en ? bus.mode       : s_mode;
  assign cur_dp     = snap_en ? bus.dp         : s_dp;
  assign cur_codes  = snap_en ? bus.codes      : s_codes;
  assign cur_bright = snap_en ? bus.brightness : s_bright;
  assign cur_num    = snap_en ? bus.num        : s_num;
  assign dsel       = 3'(idx - IDX_REFRESH - 4'd1);

  always_comb begin
    word = 16'h0000;
    case (idx)
      4'd0:        word = {ADDR_SHUTDN, 8'h01};
      4'd1:        word = {ADDR_SCANLIM, 8'(DIGIT_NUM - 1)};
      4'd2:        word = {ADDR_DECODE, 8'hFF};
      4'd3:        word = {ADDR_TEST, 8'h00};
      IDX_REFRESH: word = {ADDR_INTENS, 4'h0, cur_bright};
      default:     word = {4'h0, 4'(idx - IDX_REFRESH),
                           digit_data(dsel, cur_mode, cur_dp, cur_codes, cur_num)};
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_INIT;
      idx      <= 4'd0;
      first    <= 1'b1;
      pending  <= 1'b0;
      s_mode   <= 1'b0;
      s_dp     <= 3'd0;
      s_codes  <= 4'd0;
      s_bright <= 4'd0;
      s_num    <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (start) first <= 1'b0;
      if (snap_en) begin
        pending  <= 1'b0;
        s_mode   <= bus.mode;
        s_dp     <= bus.dp;
        s_codes  <= bus.codes;
        s_bright <= bus.brightness;
        s_num    <= bus.num;
      end else if (bus.latch && state != ST_IDLE) begin
        pending <= 1'b1;
      end
    end
  end

  // idx always names the next frame to launch; launches are chained on done.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    start     = 1'b0;
    snap_en   = 1'b0;
    case (state)
      ST_INIT: begin
        if (first || done) begin
          start   = 1'b1;
          idx_nxt = idx + 4'd1;
          if (idx == IDX_REFRESH) begin
            state_nxt = ST_REFRESH;
            snap_en   = 1'b1;
          end
        end
      end
      ST_REFRESH: begin
        if (done) begin
          if (idx > IDX_LAST) begin
            state_nxt = ST_IDLE;
            idx_nxt   = IDX_REFRESH;
          end else begin
            start   = 1'b1;
            idx_nxt = idx + 4'd1;
          end
        end
      end
      ST_IDLE: begin
        if (bus.latch || pending) begin
          state_nxt = ST_REFRESH;
          start     = 1'b1;
          snap_en   = 1'b1;
          idx_nxt   = IDX_REFRESH + 4'd1;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  max7219_display_shift #(.CLK_DIV(CLK_DIV)) u_shift (
    .clock (clock),
    .reset (reset),
    .start (start),
    .word  (word),
    .sck   (sh_sck),
    .din   (sh_din),
    .load  (sh_load),
    .done  (done)
  );

  assign bus.sck  = sh_sck;
  assign bus.din  = sh_din;
  assign bus.load = sh_load;
  assign bus.busy = (state != ST_IDLE);
endmodule

// File: tb/tb_max7219_display.sv
// Scoreboard bench for max7219_display: expected frames are queued as stimulus
// is driven; a bus monitor decodes frames from sck/din/load for comparison.
module tb_max7219_display;
  localparam int DIGIT_NUM = 8;
  localparam int CLK_DIV   = 2;
  localparam int FRAME     = 34 * CLK_DIV;
  localparam int LOAD_LOW  = 32 * CLK_DIV;

  typedef struct {
    logic [31:0] num;
    logic [2:0]  dp;
    logic        mode;
    logic [3:0]  codes;
    logic [3:0]  bright;
  } pat_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  max7219_display_if #(.DIGIT_NUM(DIGIT_NUM)) bus ();

  max7219_display #(.DIGIT_NUM(DIGIT_NUM), .CLK_DIV(CLK_DIV)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          len_q[$];

  // Frame monitor
  logic [15:0] sh = '0;
  int          nb = 0;
  int          len = 0;
  logic        p_sck = 1'b0;
  logic        p_load = 1'b1;

  always @(negedge clock) begin
    if (!reset) begin
      nb     <= 0;
      len    <= 0;
      p_sck  <= 1'b0;
      p_load <= 1'b1;
    end else begin
      p_sck  <= bus.sck;
      p_load <= bus.load;
      if (bus.load && !p_load) begin
        got_q.push_back(sh);
        len_q.push_back((nb == 16) ? len : 0);
        nb  <= 0;
        len <= 0;
      end else if (!bus.load) begin
        len <= len + 1;
        if (bus.sck && !p_sck) begin
          sh <= {sh[14:0], bus.din};
          nb <= nb + 1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [31:0] n, input logic [2:0] d, input logic m,
                       input logic [3:0] c, input logic [3:0] b);
    bus.num        = n;
    bus.dp         = d;
    bus.mode       = m;
    bus.codes      = c;
    bus.brightness = b;
  endtask

  task automatic pulse_latch();
    @(posedge clock);
    #1 bus.latch = 1'b1;
    @(posedge clock);
    #1 bus.latch = 1'b0;
  endtask

  task automatic push_init();
    exp_q.push_back(16'h0C01);
    exp_q.push_back({8'h0B, 8'(DIGIT_NUM - 1)});
    exp_q.push_back(16'h09FF);
    exp_q.push_back(16'h0F00);
  endtask

  task automatic push_refresh(input logic [31:0] n, input logic [2:0] d, input logic m,
                              input logic [3:0] c, input logic [3:0] b);
    int         h;
    logic [3:0] nib;
    logic       dpb;
    logic [3:0] help [4];
    help = '{4'hE, 4'hD, 4'hB, 4'hC};
    exp_q.push_back({8'h0A, 4'h0, b});
    h = -1;
    for (int j = 0; j < DIGIT_NUM; j++) if (n[4*j +: 4] != 4'h0) h = j;
    for (int i = 0; i < DIGIT_NUM; i++) begin
      dpb = 1'b0;
      nib = 4'hF;
      if (!m) begin
        nib = n[4*i +: 4];
        if (i > 0 && i > int'(d) && i > h) nib = 4'hF;
        dpb = (d != 3'd0) && (i == int'(d));
      end else begin
        case (c)
          4'd1:    nib = 4'hA;
          4'd2:    nib = (i < 4) ? help[i] : 4'hF;
          4'd3:    nib = (i == DIGIT_NUM - 1) ? 4'hB : 4'hA;
          default: nib = 4'hF;
        endcase
      end
      exp_q.push_back({8'(i + 1), dpb, 3'b000, nib});
    end
  endtask

  task automatic wait_quiet(output bit ok);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 5000) begin
      @(negedge clock);
      n++;
      quiet = bus.busy ? 0 : quiet + 1;
    end
    ok = (quiet >= 4);
  endtask

  task automatic test_reset();
    int cnt;
    bit ok;
    logic [15:0] e, g;
    int l;
    reset     = 1'b0;
    bus.latch = 1'b0;
    drive(32'h00000700, 3'd0, 1'b0, 4'd0, 4'd7);
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (bus.sck !== 1'b0)  begin errors++; $display("FAIL reset_sck got %b want 0", bus.sck); end
    checks++; if (bus.din !== 1'b0)  begin errors++; $display("FAIL reset_din got %b want 0", bus.din); end
    checks++; if (bus.load !== 1'b1) begin errors++; $display("FAIL reset_load got %b want 1", bus.load); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", bus.busy); end
    push_init();
    push_refresh(32'h00000700, 3'd0, 1'b0, 4'd0, 4'd7);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    cnt = 0;
    while (cnt < 20 * FRAME) begin
      @(negedge clock);
      if (!bus.busy) break;
      cnt++;
    end
    checks++;
    if (cnt != 13 * FRAME) begin
      errors++; $display("FAIL init_busy_len got %0d want %0d", cnt, 13 * FRAME);
    end
    wait_quiet(ok);
    checks++; if (!ok) begin errors++; $display("FAIL init_timeout busy still %b want 0", bus.busy); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL init_count got %0d frames want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); l = len_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL init_frame got %h want %h", g, e); end
      checks++; if (l != LOAD_LOW) begin errors++; $display("FAIL init_frame_len got %0d want %0d", l, LOAD_LOW); end
    end
    exp_q.delete(); got_q.delete(); len_q.delete();
  endtask

  task automatic test_patterns();
    pat_t pats [0:9];
    bit ok;
    logic [15:0] e, g;
    int l;
    pats[0] = '{32'h12341234, 3'd0, 1'b0, 4'd0, 4'd14};
    pats[1] = '{32'h00000042, 3'd0, 1'b0, 4'd0, 4'd3};
    pats[2] = '{32'h00000005, 3'd3, 1'b0, 4'd0, 4'd15};
    pats[3] = '{32'h00000000, 3'd0, 1'b0, 4'd0, 4'd0};
    pats[4] = '{32'h0000FA00, 3'd7, 1'b0, 4'd0, 4'd1};
    pats[5] = '{32'hEDCB9876, 3'd1, 1'b0, 4'd0, 4'd8};
    pats[6] = '{32'h00000000, 3'd0, 1'b1, 4'd2, 4'd2};
    pats[7] = '{32'h12345678, 3'd4, 1'b1, 4'd3, 4'd6};
    pats[8] = '{32'h00000001, 3'd2, 1'b1, 4'd1, 4'd9};
    pats[9] = '{32'h00000042, 3'd1, 1'b1, 4'd9, 4'd12};
    for (int p = 0; p < 10; p++) begin
      drive(pats[p].num, pats[p].dp, pats[p].mode, pats[p].codes, pats[p].bright);
      pulse_latch();
      push_refresh(pats[p].num, pats[p].dp, pats[p].mode, pats[p].codes, pats[p].bright);
      wait_quiet(ok);
      checks++; if (!ok) begin errors++; $display("FAIL pat%0d_timeout busy %b want 0", p, bus.busy); end
      checks++;
      if (got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL pat%0d_count got %0d frames want %0d", p, got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
        e = exp_q.pop_front(); g = got_q.pop_front(); l = len_q.pop_front();
        checks++; if (g !== e) begin errors++; $display("FAIL pat%0d_frame got %h want %h", p, g, e); end
        checks++; if (l != LOAD_LOW) begin errors++; $display("FAIL pat%0d_frame_len got %0d want %0d", p, l, LOAD_LOW); end
      end
      exp_q.delete(); got_q.delete(); len_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    logic [15:0] e, g;
    int l;
    drive(32'h87654321, 3'd0, 1'b0, 4'd0, 4'd5);
    pulse_latch();
    push_refresh(32'h87654321, 3'd0, 1'b0, 4'd0, 4'd5);
    repeat (3 * FRAME) @(posedge clock);
    #1 bus.num = 32'h00090807;
    pulse_latch();
    push_refresh(32'h00090807, 3'd0, 1'b0, 4'd0, 4'd5);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (bus.busy && n < 20 * FRAME);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle busy %b want 0", bus.busy); end
    @(negedge clock);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_restart busy %b want 1", bus.busy); end
    wait_quiet(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout busy %b want 0", bus.busy); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count got %0d frames want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); l = len_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_frame got %h want %h", g, e); end
      checks++; if (l != LOAD_LOW) begin errors++; $display("FAIL b2b_frame_len got %0d want %0d", l, LOAD_LOW); end
    end
    exp_q.delete(); got_q.delete(); len_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    logic [15:0] e, g;
    int l;
    drive(32'h00003141, 3'd2, 1'b0, 4'd0, 4'd9);
    pulse_latch();
    repeat (FRAME / 2) @(posedge clock);
    @(negedge clock);
    checks++; if (bus.load !== 1'b0) begin errors++; $display("FAIL midrst_pre_load got %b want 0", bus.load); end
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checks++; if (bus.load !== 1'b1) begin errors++; $display("FAIL midrst_load got %b want 1", bus.load); end
    checks++; if (bus.sck !== 1'b0)  begin errors++; $display("FAIL midrst_sck got %b want 0", bus.sck); end
    checks++; if (bus.din !== 1'b0)  begin errors++; $display("FAIL midrst_din got %b want 0", bus.din); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got %b want 1", bus.busy); end
    repeat (2) @(posedge clock);
    exp_q.delete(); got_q.delete(); len_q.delete();
    push_init();
    push_refresh(32'h00003141, 3'd2, 1'b0, 4'd0, 4'd9);
    #1 reset = 1'b1;
    wait_quiet(ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_timeout busy %b want 0", bus.busy); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL midrst_count got %0d frames want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); l = len_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL midrst_frame got %h want %h", g, e); end
      checks++; if (l != LOAD_LOW) begin errors++; $display("FAIL midrst_frame_len got %0d want %0d", l, LOAD_LOW); end
    end
    exp_q.delete(); got_q.delete(); len_q.delete();
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
